// File: rtl/config_pkg.sv
// Shared configuration for the pattern source: word width, pattern modes,
// FSM states and the LFSR tap mask.
package config_pkg;

  localparam int unsigned P_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    PG_UP    = 2'd0,
    PG_DOWN  = 2'd1,
    PG_LFSR  = 2'd2,
    PG_CONST = 2'd3
  } pg_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } pg_state_t;

  // Galois right-shift taps (x^8 + x^6 + x^5 + x^4 + 1 for 8 bits)
  localparam logic [P_DATA_WIDTH-1:0] PG_LFSR_TAPS = P_DATA_WIDTH'(8'hB8);

endpackage

// File: rtl/pattern_next.sv
// Combinational next-word function for the pattern source; shared with the
// receive-side checker so both ends agree on the sequence.
module pattern_next
  import config_pkg::*;
#(
  parameter int unsigned          P_WIDTH = P_DATA_WIDTH,
  parameter logic [P_WIDTH-1:0]   P_TAPS  = P_WIDTH'(PG_LFSR_TAPS)
) (
  input  pg_mode_t             mode_i,
  input  logic [P_WIDTH-1:0]   data_i,
  output logic [P_WIDTH-1:0]   data_next_c
);

  always_comb begin
    data_next_c = data_i;
    unique case (mode_i)
      PG_UP:   data_next_c = data_i + P_WIDTH'(1);
      PG_DOWN: data_next_c = data_i - P_WIDTH'(1);
      PG_LFSR: data_next_c = (data_i >> 1) ^ (data_i[0] ? P_TAPS : '0);
      default: data_next_c = data_i;
    endcase
  end

endmodule

// File: rtl/pattern_gen.sv
// Burst test-data source on a valid/ready stream: up/down count, LFSR or
// constant words, with last marking, backpressure hold and a done pulse.
module pattern_gen
  import config_pkg::pg_mode_t, config_pkg::pg_state_t,
         config_pkg::PG_UP, config_pkg::PG_LFSR,
         config_pkg::IDLE, config_pkg::SEND, config_pkg::FINISH;
#(
  parameter int unsigned P_DATA_WIDTH = config_pkg::P_DATA_WIDTH,
  parameter int unsigned P_LEN_WIDTH  = 8
) (
  input  logic                    clk_100,
  input  logic                    a_rst_n,
  input  logic                    s_rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [P_DATA_WIDTH-1:0] seed,
  input  logic [P_LEN_WIDTH-1:0]  burst_len,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  input  logic                    ready,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    last
);

  pg_state_t                 state_q, state_d;
  pg_mode_t                  mode_q, mode_d;
  logic [P_DATA_WIDTH-1:0]   data_q, data_d, data_next_c;
  logic [P_LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      last_q, last_d;

  pattern_next #(
    .P_WIDTH (P_DATA_WIDTH)
  ) u_next (
    .mode_i      (mode_q),
    .data_i      (data_q),
    .data_next_c (data_next_c)
  );

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      mode_q  <= PG_UP;
      data_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            mode_d  = pg_mode_t'(mode);
            rem_d   = burst_len;
            // An all-zero LFSR state would never leave zero
            data_d  = ((pg_mode_t'(mode) == PG_LFSR) && (seed == '0))
                      ? P_DATA_WIDTH'(1) : seed;
            state_d = SEND;
          end else begin
            state_d = FINISH;
          end
        end
      end
      SEND: begin
        if (ready) begin
          if (rem_q > P_LEN_WIDTH'(1)) begin
            data_d = data_next_c;
            rem_d  = rem_q - P_LEN_WIDTH'(1);
          end else begin
            rem_d   = '0;
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (s_rst) begin
      state_d = IDLE;
      mode_d  = PG_UP;
      data_d  = '0;
      rem_d   = '0;
    end

    // Outputs are registered decodes of the next state
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    last_d  = valid_d && (rem_d == P_LEN_WIDTH'(1));
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: hand-computed bursts in every mode,
// backpressure, zero-length burst, mid-burst changes and async reset.
module tb_pattern_gen;

  logic       clk_100 = 1'b0;
  logic       a_rst_n;
  logic       s_rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] burst_len;
  logic       busy, done, valid, ready, last;
  logic [7:0] data;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk_100 = ~clk_100;

  pattern_gen dut (
    .clk_100   (clk_100),
    .a_rst_n   (a_rst_n),
    .s_rst     (s_rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .ready     (ready),
    .data      (data),
    .last      (last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    @(negedge clk_100);
  endtask

  task automatic beat(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".data"},  32'(data),  32'(d));
    chk({tag, ".last"},  32'(last),  32'(l));
    chk({tag, ".busy"},  32'(busy),  32'd1);
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] s, input logic [7:0] len);
    mode = m; seed = s; burst_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, ".fin_valid"}, 32'(valid), 32'd0);
    chk({tag, ".fin_done"},  32'(done),  32'd1);
    chk({tag, ".fin_busy"},  32'(busy),  32'd1);
    step();
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] up_exp [4];
    logic [7:0] lf_exp [3];
    int words, dones;
    logic [7:0] exp_d;

    a_rst_n = 1'b0; s_rst = 1'b0; start = 1'b0; mode = 2'd0;
    seed = 8'h00; burst_len = 8'h00; ready = 1'b0;
    @(negedge clk_100);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.data",  32'(data),  32'd0);
    chk("rst.last",  32'(last),  32'd0);
    chk("rst.busy",  32'(busy),  32'd0);
    chk("rst.done",  32'(done),  32'd0);
    a_rst_n = 1'b1;
    step();

    // Up-count with wrap
    up_exp[0] = 8'hFE; up_exp[1] = 8'hFF; up_exp[2] = 8'h00; up_exp[3] = 8'h01;
    ready = 1'b1;
    launch(2'd0, 8'hFE, 8'd4);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("up%0d", i), 1'b1, up_exp[i], i == 3);
      step();
    end
    finish_chk("up");

    // Down-count with backpressure on the second word
    launch(2'd1, 8'h02, 8'd3);
    beat("dn0", 1'b1, 8'h02, 1'b0);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("dn1_%0d", i), 1'b1, 8'h01, 1'b0);
      if (i < 2) step();
    end
    ready = 1'b1;
    step();
    beat("dn2", 1'b1, 8'h00, 1'b1);
    step();
    finish_chk("dn");

    // LFSR with zero seed: 01 -> B8 -> 5C
    lf_exp[0] = 8'h01; lf_exp[1] = 8'hB8; lf_exp[2] = 8'h5C;
    launch(2'd2, 8'h00, 8'd3);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("lf%0d", i), 1'b1, lf_exp[i], i == 2);
      step();
    end
    finish_chk("lf");

    // Constant pattern
    launch(2'd3, 8'hA5, 8'd2);
    beat("cst0", 1'b1, 8'hA5, 1'b0);
    step();
    beat("cst1", 1'b1, 8'hA5, 1'b1);
    step();
    finish_chk("cst");

    // Zero-length burst: straight to finish, busy for one cycle
    launch(2'd0, 8'h33, 8'd0);
    finish_chk("zero");

    // Restart attempt and input changes mid-burst are ignored
    mode = 2'd0; seed = 8'h10; burst_len = 8'd3; start = 1'b1;
    step();
    seed = 8'h55; burst_len = 8'd9; mode = 2'd1;
    words = 0; dones = 0; exp_d = 8'h10;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) start = 1'b0;
      if (valid) begin
        chk($sformatf("mid.data%0d", words), 32'(data), 32'(exp_d));
        exp_d = exp_d + 8'd1;
        words++;
      end
      if (done) dones++;
      step();
    end
    chk("mid.words", 32'(words), 32'd3);
    chk("mid.dones", 32'(dones), 32'd1);
    chk("mid.busy",  32'(busy),  32'd0);

    // Async reset while stalled
    ready = 1'b0;
    launch(2'd0, 8'h40, 8'd5);
    beat("ar0", 1'b1, 8'h40, 1'b0);
    #2 a_rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(valid), 32'd0);
    chk("ar.busy",  32'(busy),  32'd0);
    chk("ar.data",  32'(data),  32'd0);
    chk("ar.last",  32'(last),  32'd0);
    step();
    chk("ar.done", 32'(done), 32'd0);
    a_rst_n = 1'b1;
    step();
    chk("ar.idle_done", 32'(done), 32'd0);
    ready = 1'b1;
    launch(2'd0, 8'h07, 8'd2);
    beat("ar1", 1'b1, 8'h07, 1'b0);
    step();
    beat("ar2", 1'b1, 8'h08, 1'b1);
    step();
    finish_chk("ar");

    // Synchronous clear aborts a burst with no done
    launch(2'd0, 8'h20, 8'd4);
    beat("sr0", 1'b1, 8'h20, 1'b0);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("sr.valid", 32'(valid), 32'd0);
    chk("sr.busy",  32'(busy),  32'd0);
    chk("sr.done",  32'(done),  32'd0);
    chk("sr.data",  32'(data),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
